ifetch_queue: RTL and testbench

// Instruction fetch stage directly upstream of the instruction decoder. Holds the fetch PC.

---
 rtl/ifetch_queue.sv | 125 ++++++++++++
 tb/tb_ifetch_queue.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues single outstanding word reads and
// buffers returned instructions in a small FIFO presented to decode via valid/ready.
module ifetch_queue #(
  parameter int unsigned           REG_WIDTH  = 16,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [REG_WIDTH-1:0]  mem_rdata_i,
  output logic                  ins_valid_o,
  input  logic                  ins_ready_i,
  output logic [REG_WIDTH-1:0]  ins_o,
  output logic [ADDR_WIDTH-1:0] ins_pc_o,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i
);

  localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] drop_addr_q, drop_addr_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, cnt_after_pop;
  logic [REG_WIDTH-1:0]  data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [FIFO_DEPTH];
  logic                  push, pop, flush;

  assign ins_valid_o = (count_q != '0);
  assign ins_o       = data_q[rd_ptr_q];
  assign ins_pc_o    = pc_q[rd_ptr_q];
  assign mem_req_o   = (state_q != IDLE);
  // While dropping, the abandoned address must stay on the bus until its ack.
  assign mem_addr_o  = (state_q == DROP) ? drop_addr_q : fetch_pc_q;

  // Redirect wins over pop: the whole buffer is discarded anyway.
  assign pop           = ins_valid_o & ins_ready_i & ~redirect_i;
  assign cnt_after_pop = count_q - CNT_W'(pop);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    push        = 1'b0;
    flush       = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_i) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc_i;
          state_d    = REQ;
        end else if (cnt_after_pop < DEPTH_C) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_i) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc_i;
          if (!mem_ack_i) begin
            drop_addr_d = fetch_pc_q;
            state_d     = DROP;
          end
        end else if (mem_ack_i) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
          state_d    = (cnt_after_pop + CNT_W'(1) < DEPTH_C) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (redirect_i) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc_i;
        end
        if (mem_ack_i) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          data_q[wr_ptr_q] <= mem_rdata_i;
          pc_q[wr_ptr_q]   <= fetch_pc_q;
          wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a memory model with programmable ack latency returns
// 0x1000+addr; each step checks hand-derived outputs with immediate assertions.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_ack, ins_valid, ins_ready, redirect;
  logic [15:0] mem_addr, mem_rdata, ins, ins_pc, redirect_pc;
  int          lat;
  int          wcnt;
  int          vecs = 0;
  int          errs = 0;

  ifetch_queue #(.REG_WIDTH(16), .ADDR_WIDTH(16), .RESET_PC(16'h0000), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .ins_valid_o(ins_valid), .ins_ready_i(ins_ready), .ins_o(ins), .ins_pc_o(ins_pc),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory: ack once the request has waited 'lat' cycles (lat=0 -> same cycle).
  assign mem_ack   = mem_req && (wcnt == lat);
  assign mem_rdata = 16'h1000 + mem_addr;
  always @(posedge clk) begin
    if (!rst_n || !mem_req || mem_ack) wcnt <= 0;
    else                               wcnt <= wcnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reset, release, then run n zero-wait fetches with decode always ready.
  task automatic reset_and_stream(input int n);
    lat = 0; ins_ready = 1'b1; redirect = 1'b0;
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; tick();
    repeat (n) tick();
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 12 && !ins_valid; k++) tick();
    check(tag, ins_valid, 1);
  endtask

  initial begin
    rst_n = 1'b0; ins_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; lat = 0;

    // T1: reset state and first request after release
    tick(); tick(); tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_ins_valid", ins_valid, 0);
    check("rst_ins", ins, 0);
    check("rst_ins_pc", ins_pc, 0);
    rst_n = 1'b1; tick();
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_addr", mem_addr, 16'h0000);
    check("t1_ins_valid", ins_valid, 0);

    // T2: streaming at one instruction per cycle (ack this cycle -> valid next)
    ins_ready = 1'b1; tick();
    for (int i = 0; i < 6; i++) begin
      check("t2_valid", ins_valid, 1);
      check("t2_ins", ins, 32'h1000 + i);
      check("t2_pc", ins_pc, i);
      tick();
    end

    // T3: backpressure fills the FIFO, then fetch resumes at 2
    ins_ready = 1'b0; rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; tick();
    tick();
    check("t3_req_after_1", mem_req, 1);
    check("t3_addr_1", mem_addr, 16'h0001);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t3_req_idle", mem_req, 0);
      check("t3_hold_ins", ins, 16'h1000);
      check("t3_hold_pc", ins_pc, 0);
      tick();
    end
    ins_ready = 1'b1; tick();
    check("t3_resume_req", mem_req, 1);
    check("t3_resume_addr", mem_addr, 16'h0002);
    check("t3_ins1", ins, 16'h1001);
    tick();
    check("t3_ins2", ins, 16'h1002);
    check("t3_pc2", ins_pc, 16'h0002);
    tick();
    check("t3_pc3", ins_pc, 16'h0003);

    // T4: redirect while a slow request to 0x0005 is pending
    reset_and_stream(5);
    check("t4_addr5", mem_addr, 16'h0005);
    lat = 3; redirect = 1'b1; redirect_pc = 16'h0040; tick();
    redirect = 1'b0;
    check("t4_drop_valid", ins_valid, 0);
    check("t4_drop_req", mem_req, 1);
    check("t4_drop_addr_a", mem_addr, 16'h0005);
    tick();
    check("t4_drop_addr_b", mem_addr, 16'h0005);
    tick();
    check("t4_drop_addr_c", mem_addr, 16'h0005);
    tick();
    check("t4_new_addr", mem_addr, 16'h0040);
    check("t4_no_stale", ins_valid, 0);
    wait_valid("t4_timeout");
    check("t4_first_pc", ins_pc, 16'h0040);
    check("t4_first_ins", ins, 16'h1040);

    // T5: redirect again in DROP, final one landing with the drop ack
    reset_and_stream(5);
    lat = 3; redirect = 1'b1; redirect_pc = 16'h0040; tick();
    redirect_pc = 16'h0060; tick();
    check("t5_drop_addr", mem_addr, 16'h0005);
    redirect_pc = 16'h0080; tick();
    tick();
    redirect = 1'b0;
    check("t5_new_addr", mem_addr, 16'h0080);
    check("t5_no_stale", ins_valid, 0);
    wait_valid("t5_timeout");
    check("t5_first_pc", ins_pc, 16'h0080);
    check("t5_first_ins", ins, 16'h1080);

    // T6: redirect coinciding with ack, PC wrap, then mid-stream reset
    reset_and_stream(3);
    redirect = 1'b1; redirect_pc = 16'hFFFF; tick();
    redirect = 1'b0;
    check("t6_redir_addr", mem_addr, 16'hFFFF);
    check("t6_redir_valid", ins_valid, 0);
    tick();
    check("t6_pc_ffff", ins_pc, 16'hFFFF);
    check("t6_ins_ffff", ins, 16'h0FFF);
    check("t6_wrap_addr", mem_addr, 16'h0000);
    tick();
    check("t6_pc_0000", ins_pc, 16'h0000);
    check("t6_ins_0000", ins, 16'h1000);
    rst_n = 1'b0; tick();
    check("t6_rst_valid", ins_valid, 0);
    check("t6_rst_req", mem_req, 0);
    check("t6_rst_addr", mem_addr, 16'h0000);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
